pong_game_ctrl: RTL and testbench

//  Top-level game sequencer for Pong. Drives the 2-bit game state (START/SERVE/PLAY/DONE) consumed by the ball

---
 rtl/pong_defs.sv | 29 ++
 rtl/pong_btn_edge.sv | 29 ++
 rtl/pong_game_ctrl.sv | 142 ++++++++++++++
 tb/tb_pong_game_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/pong_defs.sv
// pong_defs: state, ball-status and winner codes shared by the Pong ball datapath and game sequencer.
`default_nettype none

package pong_defs;

  typedef enum logic [1:0] {
    START = 2'b00,
    SERVE = 2'b01,
    PLAY  = 2'b10,
    DONE  = 2'b11
  } gameState_t;

  typedef enum logic [1:0] {
    PLAYING    = 2'b00,
    PLAYER1WIN = 2'b01,
    PLAYER2WIN = 2'b10
  } ballStatus_t;

  localparam logic [1:0] c_WIN_NONE = 2'b00;
  localparam logic [1:0] c_WIN_P1   = 2'b01;
  localparam logic [1:0] c_WIN_P2   = 2'b10;

  function automatic int cntWidth(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/pong_btn_edge.sv
// pong_btn_edge: registers a debounced button through two flops and emits a one-cycle rising-edge pulse.
// Rev 1.0
`default_nettype none

module pong_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  logic r_sync;
  logic r_prev;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= btn;
      r_prev <= r_sync;
    end
  end

  assign pulse = r_sync & ~r_prev;

endmodule

`default_nettype wire

// File: rtl/pong_game_ctrl.sv
// pong_game_ctrl: Pong game sequencer (state, serve direction, scores, winner, collision-clear strobe).
// Optional PONG_AUTO_SERVE_EN adds a SERVE timeout that launches the ball without a button. Rev 1.0
`default_nettype none

module pong_game_ctrl
  import pong_defs::*;
#(
  parameter int                 SCORE_W     = 4,
  parameter logic [SCORE_W-1:0] WIN_SCORE   = SCORE_W'(7),
  parameter int                 CLR_PERIOD  = 524288,
  parameter int                 SERVE_DELAY = 25000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_serve,
  input  logic [1:0]         ball_status,
  output logic [1:0]         state,
  output logic               serve,
  output logic [SCORE_W-1:0] score1,
  output logic [SCORE_W-1:0] score2,
  output logic [1:0]         winner,
  output logic               collision_clr
);

  localparam int                 c_CLR_W    = cntWidth(CLR_PERIOD);
  localparam logic [c_CLR_W-1:0] c_CLR_LAST = c_CLR_W'(CLR_PERIOD - 1);

  gameState_t         r_state;
  logic               r_serve;
  logic [SCORE_W-1:0] r_score1;
  logic [SCORE_W-1:0] r_score2;
  logic [1:0]         r_winner;
  logic               r_clr;
  logic [c_CLR_W-1:0] r_clrCnt;

  logic               w_startEdge;
  logic               w_serveEdge;
  logic               w_autoServe;
  logic [c_CLR_W-1:0] w_clrNext;
  logic [SCORE_W-1:0] w_score1Inc;
  logic [SCORE_W-1:0] w_score2Inc;

  pong_btn_edge u_startEdge (.clk(clk), .rst(rst), .btn(btn_start), .pulse(w_startEdge));
  pong_btn_edge u_serveEdge (.clk(clk), .rst(rst), .btn(btn_serve), .pulse(w_serveEdge));

  assign w_clrNext   = (r_clrCnt == c_CLR_LAST) ? '0 : r_clrCnt + 1'b1;
  assign w_score1Inc = r_score1 + 1'b1;
  assign w_score2Inc = r_score2 + 1'b1;

`ifdef PONG_AUTO_SERVE_EN
  localparam int c_SRV_W = cntWidth(SERVE_DELAY);

  logic [c_SRV_W-1:0] r_srvTmr;

  // Any cycle outside SERVE clears the timer, so every SERVE entry starts from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_srvTmr <= '0;
    end else if (r_state == SERVE) begin
      r_srvTmr <= r_srvTmr + 1'b1;
    end else begin
      r_srvTmr <= '0;
    end
  end

  assign w_autoServe = (r_srvTmr == c_SRV_W'(SERVE_DELAY - 1));
`else
  assign w_autoServe = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= START;
      r_serve  <= 1'b0;
      r_score1 <= '0;
      r_score2 <= '0;
      r_winner <= c_WIN_NONE;
      r_clr    <= 1'b0;
      r_clrCnt <= '0;
    end else begin
      r_clr <= 1'b0;
      case (r_state)
        START: begin
          if (w_startEdge) r_state <= SERVE;
        end
        SERVE: begin
          if (w_serveEdge || w_autoServe) begin
            r_state <= PLAY;
            r_clr   <= (c_CLR_LAST == '0);
          end
        end
        PLAY: begin
          // A point ends the rally on the same edge, so status is counted only once.
          if (ball_status == PLAYER1WIN) begin
            r_score1 <= w_score1Inc;
            r_serve  <= 1'b0;
            r_clrCnt <= '0;
            if (w_score1Inc == WIN_SCORE) begin
              r_state  <= DONE;
              r_winner <= c_WIN_P1;
            end else begin
              r_state  <= SERVE;
            end
          end else if (ball_status == PLAYER2WIN) begin
            r_score2 <= w_score2Inc;
            r_serve  <= 1'b1;
            r_clrCnt <= '0;
            if (w_score2Inc == WIN_SCORE) begin
              r_state  <= DONE;
              r_winner <= c_WIN_P2;
            end else begin
              r_state  <= SERVE;
            end
          end else begin
            r_clrCnt <= w_clrNext;
            r_clr    <= (w_clrNext == c_CLR_LAST);
          end
        end
        DONE: begin
          if (w_startEdge) begin
            r_state  <= START;
            r_score1 <= '0;
            r_score2 <= '0;
            r_winner <= c_WIN_NONE;
            r_serve  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign state         = r_state;
  assign serve         = r_serve;
  assign score1        = r_score1;
  assign score2        = r_score2;
  assign winner        = r_winner;
  assign collision_clr = r_clr;

endmodule

`default_nettype wire

// File: tb/tb_pong_game_ctrl.sv
// tb_pong_game_ctrl: directed self-checking bench for pong_game_ctrl with small simulation parameters.
`default_nettype none

module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       btnStart;
  logic       btnServe;
  logic [1:0] ballStatus;
  logic [1:0] state;
  logic       serve;
  logic [3:0] score1;
  logic [3:0] score2;
  logic [1:0] winner;
  logic       collisionClr;

  int nChecks = 0;
  int nPass   = 0;

  pong_game_ctrl #(
    .SCORE_W    (4),
    .WIN_SCORE  (4'd2),
    .CLR_PERIOD (8),
    .SERVE_DELAY(5)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .btn_start    (btnStart),
    .btn_serve    (btnServe),
    .ball_status  (ballStatus),
    .state        (state),
    .serve        (serve),
    .score1       (score1),
    .score2       (score2),
    .winner       (winner),
    .collision_clr(collisionClr)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    nChecks++;
    if (obs == exp) nPass++;
    else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pressStart();
    btnStart = 1'b1;
    tick();
    btnStart = 1'b0;
    tick();
  endtask

  task automatic pressServe();
    btnServe = 1'b1;
    tick();
    btnServe = 1'b0;
    tick();
  endtask

  initial begin
    int nEntries;
    int leaveAt;
    logic [1:0] prevState;

    rst = 1'b0; btnStart = 1'b0; btnServe = 1'b0; ballStatus = 2'b00;
    tick(); tick();
    check("rst_state", state, 0);
    check("rst_serve", serve, 0);
    check("rst_score1", score1, 0);
    check("rst_score2", score2, 0);
    check("rst_winner", winner, 0);
    check("rst_clr", collisionClr, 0);
    rst = 1'b1;
    tick();

    // START ignores serve, advances on start
    pressServe();
    check("start_ign_serve", state, 0);
    pressStart();
    check("start_to_serve", state, 1);
    pressStart();
    check("serve_ign_start", state, 1);
    pressServe();
    check("serve_to_play", state, 2);

    for (int k = 0; k < 24; k++) begin
      check($sformatf("clr_play_cyc%0d", k), collisionClr, (k % 8 == 7) ? 1 : 0);
      tick();
    end

    // player1 scores, status held three cycles
    ballStatus = 2'b01;
    tick();
    check("p1pt_score1", score1, 1);
    check("p1pt_state", state, 1);
    check("p1pt_serve", serve, 0);
    check("p1pt_clr", collisionClr, 0);
    tick(); tick();
    check("p1pt_once", score1, 1);
    check("serve_clr_low", collisionClr, 0);
    ballStatus = 2'b00;

    pressServe();
    check("play2", state, 2);
    ballStatus = 2'b10;
    tick();
    ballStatus = 2'b00;
    check("p2pt_score2", score2, 1);
    check("p2pt_serve", serve, 1);
    check("p2pt_state", state, 1);
    check("p2pt_score1", score1, 1);

    pressServe();
    ballStatus = 2'b01;
    tick();
    ballStatus = 2'b00;
    check("win_score1", score1, 2);
    check("win_state", state, 3);
    check("win_winner", winner, 1);
    check("win_serve", serve, 0);
    ballStatus = 2'b10;
    tick();
    ballStatus = 2'b00;
    check("done_frozen_s2", score2, 1);
    check("done_clr", collisionClr, 0);
    pressServe();
    check("done_ign_serve", state, 3);
    pressStart();
    check("done_to_start", state, 0);
    check("done_clr_s1", score1, 0);
    check("done_clr_s2", score2, 0);
    check("done_clr_win", winner, 0);

    // simultaneous edges: only the legal one acts
    btnStart = 1'b1; btnServe = 1'b1;
    tick();
    btnStart = 1'b0; btnServe = 1'b0;
    tick();
    check("both_in_start", state, 1);
    tick();
    check("both_in_start_hold", state, 1);
    btnStart = 1'b1; btnServe = 1'b1;
    tick();
    btnStart = 1'b0; btnServe = 1'b0;
    tick();
    check("both_in_serve", state, 2);
    tick();
    check("both_in_serve_hold", state, 2);

    // asynchronous reset in PLAY with a non-zero score
    ballStatus = 2'b10;
    tick();
    ballStatus = 2'b00;
    check("pre_rst_s2", score2, 1);
    pressServe();
    tick();
    ballStatus = 2'b01;
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_s1", score1, 0);
    check("arst_s2", score2, 0);
    check("arst_serve", serve, 0);
    check("arst_winner", winner, 0);
    check("arst_clr", collisionClr, 0);
    @(posedge clk); #1;
    ballStatus = 2'b00;
    rst = 1'b1;
    tick();

    // held start fires exactly once
    nEntries  = 0;
    prevState = state;
    btnStart  = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (prevState == 2'b00 && state == 2'b01) nEntries++;
      prevState = state;
    end
    btnStart = 1'b0;
    tick();
    check("held_start_once", nEntries, 1);

    // SERVE with no buttons
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    pressStart();
    check("auto_enter_serve", state, 1);
    leaveAt = 0;
    for (int i = 1; i <= 100; i++) begin
      tick();
      if (state == 2'b10 && leaveAt == 0) leaveAt = i;
    end
`ifdef PONG_AUTO_SERVE_EN
    check("auto_serve_cycles", leaveAt, 5);
`else
    check("no_auto_serve", leaveAt, 0);
`endif

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule

`default_nettype wire
